// File: rtl/tcam_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// tcam_pkg : shared NID/opcode constants and dispatcher FSM states
// Rev 1.0
// ---------------------------------------------------------------
package tcam_pkg;

  localparam logic [6:0] C_NID_RN1 = 7'b0000001;
  localparam logic [6:0] C_NID_RN2 = 7'b0000010;
  localparam logic [6:0] C_NID_RN3 = 7'b0000100;
  localparam logic [6:0] C_NID_RN4 = 7'b0001000;

  localparam logic [6:0] C_OP_READ_SHARED    = 7'b0000001;
  localparam logic [6:0] C_OP_READ_UNIQUE    = 7'b0000111;
  localparam logic [6:0] C_OP_WRITE_BACK_FULL = 7'b0011011;

  localparam int C_NUM_RN = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/snoop_channel.sv
`default_nettype none
// ---------------------------------------------------------------
// snoop_channel : per-RN pending/outstanding tracking with issue
//                 and response handshakes
// Rev 1.0
// ---------------------------------------------------------------
module snoop_channel
  import tcam_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_req_bit,
  input  logic i_issue_en,
  input  logic i_rsp_en,
  input  logic i_clear,
  input  logic i_snp_ready,
  input  logic i_rsp_valid,
  input  logic i_rsp_dirty,
  output logic o_snp_valid,
  output logic o_issued,
  output logic o_dirty_hit,
  output logic o_pending_nxt,
  output logic o_outstanding_nxt
);

  logic pending_q, pending_d;
  logic outstanding_q, outstanding_d;
  logic w_hs;
  logic w_rsp_hit;

  // The *_nxt outputs exclude the clear so the parent can derive the
  // timeout abort from them without a combinational loop.
  always_comb begin
    w_hs              = i_issue_en & pending_q & i_snp_ready;
    w_rsp_hit         = i_rsp_en & outstanding_q & i_rsp_valid;
    o_pending_nxt     = pending_q & ~w_hs;
    o_outstanding_nxt = (outstanding_q & ~w_rsp_hit) | w_hs;
    pending_d         = o_pending_nxt;
    outstanding_d     = o_outstanding_nxt;
    if (i_clear) begin
      pending_d     = 1'b0;
      outstanding_d = 1'b0;
    end else if (i_load) begin
      pending_d     = i_req_bit;
      outstanding_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= 1'b0;
      outstanding_q <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign o_snp_valid = i_issue_en & pending_q;
  assign o_issued    = w_hs;
  assign o_dirty_hit = w_rsp_hit & i_rsp_dirty;

endmodule
`default_nettype wire

// File: rtl/snoop_dispatch.sv
`default_nettype none
// ---------------------------------------------------------------
// snoop_dispatch : fans a filtered request out as per-RN snoops,
//                  collects responses and reports completion
// Rev 1.0
// ---------------------------------------------------------------
module snoop_dispatch
  import tcam_pkg::*;
#(
  parameter int WIDTH   = 33,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_tag,
  input  logic [6:0]       req_opcode,
  input  logic [6:0]       req_nid,
  input  logic [3:0]       req_flag,
  output logic [3:0]       snp_valid,
  input  logic [3:0]       snp_ready,
  output logic [WIDTH-1:0] snp_tag,
  output logic             snp_type,
  input  logic [3:0]       rsp_valid,
  input  logic [3:0]       rsp_dirty,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [6:0]       done_nid,
  output logic [WIDTH-1:0] done_tag,
  output logic [3:0]       done_snooped,
  output logic             done_dirty,
  output logic             done_timeout
);

  localparam int C_TW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tag_q, tag_d;
  logic [6:0]       nid_q, nid_d;
  logic             snp_type_q, snp_type_d;
  logic [C_TW-1:0]  timer_q, timer_d;
  logic [3:0]       snooped_q, snooped_d;
  logic             dirty_q, dirty_d;
  logic             timeout_q, timeout_d;

  logic             w_accept;
  logic             w_skip;
  logic [3:0]       w_load_bits;
  logic             w_active;
  logic             w_issue_en;
  logic [3:0]       w_issued;
  logic [3:0]       w_dirty_hit;
  logic [3:0]       w_pend_nxt;
  logic [3:0]       w_outs_nxt;
  logic             w_all_done;
  logic             w_timeout;

  assign w_accept    = req_valid & (state_q == ST_IDLE);
  assign w_skip      = ((req_flag & ~req_nid[3:0]) == 4'b0000) ||
                       (req_opcode == C_OP_WRITE_BACK_FULL);
  // Write-backs never snoop, so nothing is loaded into the channels.
  assign w_load_bits = w_skip ? 4'b0000 : (req_flag & ~req_nid[3:0]);
  assign w_active    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign w_issue_en  = (state_q == ST_ISSUE);
  assign w_all_done  = (w_pend_nxt == 4'b0000) && (w_outs_nxt == 4'b0000);
  assign w_timeout   = w_active && (timer_q == C_TW'(TIMEOUT - 1)) && !w_all_done;

  generate
    for (genvar i = 0; i < C_NUM_RN; i++) begin : g_rn
      snoop_channel u_chan (
        .clk               (clk),
        .reset             (reset),
        .i_load            (w_accept),
        .i_req_bit         (w_load_bits[i]),
        .i_issue_en        (w_issue_en),
        .i_rsp_en          (w_active),
        .i_clear           (w_timeout),
        .i_snp_ready       (snp_ready[i]),
        .i_rsp_valid       (rsp_valid[i]),
        .i_rsp_dirty       (rsp_dirty[i]),
        .o_snp_valid       (snp_valid[i]),
        .o_issued          (w_issued[i]),
        .o_dirty_hit       (w_dirty_hit[i]),
        .o_pending_nxt     (w_pend_nxt[i]),
        .o_outstanding_nxt (w_outs_nxt[i])
      );
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    nid_d      = nid_q;
    snp_type_d = snp_type_q;
    timer_d    = timer_q;
    snooped_d  = snooped_q;
    dirty_d    = dirty_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          tag_d      = req_tag;
          nid_d      = req_nid;
          snp_type_d = (req_opcode == C_OP_READ_UNIQUE);
          timer_d    = '0;
          snooped_d  = 4'b0000;
          dirty_d    = 1'b0;
          timeout_d  = 1'b0;
          state_d    = w_skip ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        timer_d   = timer_q + C_TW'(1);
        snooped_d = snooped_q | w_issued;
        dirty_d   = dirty_q | (|w_dirty_hit);
        // Completion takes priority over a coincident timeout.
        if (w_all_done) begin
          state_d = ST_DONE;
        end else if (w_timeout) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end else if ((state_q == ST_ISSUE) && (w_pend_nxt == 4'b0000)) begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tag_q      <= '0;
      nid_q      <= '0;
      snp_type_q <= 1'b0;
      timer_q    <= '0;
      snooped_q  <= 4'b0000;
      dirty_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      nid_q      <= nid_d;
      snp_type_q <= snp_type_d;
      timer_q    <= timer_d;
      snooped_q  <= snooped_d;
      dirty_q    <= dirty_d;
      timeout_q  <= timeout_d;
    end
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign snp_tag      = tag_q;
  assign snp_type     = snp_type_q;
  assign done_valid   = (state_q == ST_DONE);
  assign done_nid     = nid_q;
  assign done_tag     = tag_q;
  assign done_snooped = snooped_q;
  assign done_dirty   = dirty_q;
  assign done_timeout = timeout_q;

endmodule
`default_nettype wire

// File: doc/snoop_dispatch.md
SNOOP_DISPATCH -- requirements
Module: snoop_dispatch

Interface
REQ-001 Parameter WIDTH, default 33, tag width.
REQ-002 Parameter TIMEOUT, default 255, max cycles waiting for snoop responses.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  filter result valid; req_ready  out  1  block accepts request.
REQ-006 req_tag  in  WIDTH; req_opcode  in  7; req_nid  in  7 (one-hot RN1..RN4); req_flag  in  4, bit i = snoop RN(i+1).
REQ-007 snp_valid  out  4, per-RN snoop request; snp_ready  in  4, per-RN accept.
REQ-008 snp_tag  out  WIDTH, captured tag; snp_type  out  1, 0 = shared snoop, 1 = unique (invalidate) snoop.
REQ-009 rsp_valid  in  4, per-RN snoop response pulse; rsp_dirty  in  4, response carries dirty data.
REQ-010 done_valid  out  1; done_ready  in  1; done_nid  out  7; done_tag  out  WIDTH; done_snooped  out  4; done_dirty  out  1; done_timeout  out  1.

Function
REQ-011 FSM states: IDLE, ISSUE, WAIT, DONE; req_ready = 1 only in IDLE.
REQ-012 IDLE: on req_valid && req_ready, capture tag, opcode, nid, flag; pending = flag & ~nid[3:0]; outstanding = 0; timer = 0.
REQ-013 Capture with pending == 0 or opcode == WRITE_BACK_FULL (7'b0011011) -> DONE next cycle; done_valid high 1 cycle after accept.
REQ-014 Otherwise -> ISSUE; snp_type = 1 for READ_UNIQUE (7'b0000111), 0 for all other opcodes.
REQ-015 ISSUE: snp_valid = pending; on snp_valid[i] && snp_ready[i], clear pending[i], set outstanding[i], set done_snooped[i]; snp_valid/snp_tag/snp_type stable until handshake.
REQ-016 Per-RN handshakes independent; any subset may complete in one cycle.
REQ-017 ISSUE -> WAIT when pending becomes 0 (evaluated after the cycle's handshakes).
REQ-018 rsp_valid[i] counts only if outstanding[i] was set in a prior cycle; counted response clears outstanding[i], ORs rsp_dirty[i] into done_dirty.
REQ-019 rsp_valid[i] with outstanding[i] = 0 (spurious or same cycle as issue) is ignored, no state change.
REQ-020 Responses are accepted in both ISSUE and WAIT.
REQ-021 WAIT -> DONE when outstanding == 0 and pending == 0.
REQ-022 Timer increments every cycle in ISSUE/WAIT; timer reaching TIMEOUT -> DONE, done_timeout = 1; pending and outstanding cleared; snp_valid drops.
REQ-023 Completion and timeout in the same cycle: completion wins, done_timeout = 0.
REQ-024 DONE: done_valid = 1, done_* stable; on done_ready -> IDLE; no new request accepted in that same cycle.
REQ-025 done_nid/done_tag = captured values; done_snooped = RNs actually issued to.

Reset
REQ-026 reset low: state = IDLE, req_ready = 1, snp_valid = 0, done_valid = 0.
REQ-027 reset low: pending, outstanding, timer, done_snooped, done_dirty, done_timeout = 0; snp_tag, done_tag, done_nid = 0.
REQ-028 Reset asserted mid-ISSUE/WAIT abandons the transaction; no done is produced for it.

Structure
REQ-029 Shared package tcam_pkg holds RN1..RN4 NID constants, opcode constants (READ_SHARED, READ_UNIQUE, WRITE_BACK_FULL), and the FSM state enum.
REQ-030 One sub-module, snoop_channel, instantiated 4x, holds per-RN pending/outstanding bits and the issue/response handshake; the parent holds FSM, timer and capture registers.

Verification
REQ-031 nid = RN1, opcode = READ_SHARED, flag = 4'b0110, snp_ready = 1, responses 2 cycles later -> snp_valid = 0110, snp_type = 0, done_snooped = 0110, done_timeout = 0.
REQ-032 flag = 4'b0000 accepted cycle N -> done_valid at N+1, done_snooped = 0, no snp_valid asserted.
REQ-033 READ_UNIQUE, flag = 4'b1000, snp_ready[3] held low 5 cycles -> snp_valid[3] held stable, snp_type = 1; after ready, rsp_dirty[3] = 1 -> done_dirty = 1.
REQ-034 flag = 4'b0011, RN2 never responds, TIMEOUT = 8 -> done_timeout = 1 after 8 cycles in ISSUE/WAIT, done_snooped = 0011.
REQ-035 Spurious rsp_valid = 4'b1111 while outstanding = 0100 -> only bit 2 cleared; reset pulse in WAIT -> IDLE, done_valid stays 0.
